// File: rtl/vend_ctrl_if.sv
// Vending controller key/status bundle.
//   flag_key   : one-cycle key pulses [0] coin A, [1] coin B, [2] select, [3] cancel
//   balance    : current credit in jiao
//   dispense   : dispense strobe
//   change     : last refunded amount (held until the next refund)
//   change_vld : one-cycle strobe, change valid
//   reject     : one-cycle strobe, key event refused
//   busy       : controller is vending or refunding
// master drives the keys and observes status; slave is the controller.
interface vend_ctrl_if;
  logic [3:0] flag_key;
  logic [6:0] balance;
  logic       dispense;
  logic [6:0] change;
  logic       change_vld;
  logic       reject;
  logic       busy;

  modport master (
    output flag_key,
    input  balance, dispense, change, change_vld, reject, busy
  );

  modport slave (
    input  flag_key,
    output balance, dispense, change, change_vld, reject, busy
  );
endinterface

// File: rtl/vend_ctrl.sv
// Vending transaction controller.
// Consumes debounced key pulses, tracks credit, produces a timed dispense
// strobe, returns change and times out abandoned transactions.
// Ports:
//   sclk  : system clock
//   rst_n : asynchronous active-low reset
//   bus   : vend_ctrl_if.slave (flag_key in; balance, dispense, change,
//           change_vld, reject, busy out). All outputs are registered.
module vend_ctrl #(
  parameter int unsigned PRICE       = 15,
  parameter int unsigned COIN_A      = 5,
  parameter int unsigned COIN_B      = 10,
  parameter int unsigned MAX_BAL     = 95,
  parameter int unsigned DISP_CYC    = 50_000_000,
  parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
  input  logic       sclk,
  input  logic       rst_n,
  vend_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_VEND,
    S_REFUND
  } state_t;

  state_t      state, state_nx;
  logic [6:0]  balance, balance_nx;
  logic [6:0]  change, change_nx;
  logic        change_vld, change_vld_nx;
  logic        reject, reject_nx;
  logic        dispense, dispense_nx;
  logic        busy, busy_nx;
  logic [31:0] timer, timer_nx;
  logic [31:0] dcnt, dcnt_nx;

  // Key decode with priority cancel > select > coin B > coin A.
  logic       key_any, key_cancel, key_select, key_coin;
  logic [6:0] coin_val;
  logic [7:0] coin_sum;

  always_comb begin
    key_any    = |bus.flag_key;
    key_cancel = bus.flag_key[3];
    key_select = bus.flag_key[2] & ~bus.flag_key[3];
    key_coin   = ~bus.flag_key[3] & ~bus.flag_key[2] & (bus.flag_key[1] | bus.flag_key[0]);
    coin_val   = bus.flag_key[1] ? 7'(COIN_B) : 7'(COIN_A);
    // 8-bit sum so the credit limit test can never wrap.
    coin_sum   = {1'b0, balance} + {1'b0, coin_val};
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      balance    <= '0;
      change     <= '0;
      change_vld <= 1'b0;
      reject     <= 1'b0;
      dispense   <= 1'b0;
      busy       <= 1'b0;
      timer      <= '0;
      dcnt       <= '0;
    end else begin
      state      <= state_nx;
      balance    <= balance_nx;
      change     <= change_nx;
      change_vld <= change_vld_nx;
      reject     <= reject_nx;
      dispense   <= dispense_nx;
      busy       <= busy_nx;
      timer      <= timer_nx;
      dcnt       <= dcnt_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    balance_nx    = balance;
    change_nx     = change;
    change_vld_nx = 1'b0;
    reject_nx     = 1'b0;
    dispense_nx   = dispense;
    timer_nx      = timer;
    dcnt_nx       = dcnt;

    unique case (state)
      S_IDLE: begin
        timer_nx = '0;
        if (key_select) begin
          reject_nx = 1'b1;
        end else if (key_coin) begin
          balance_nx = coin_val;
          state_nx   = S_CREDIT;
        end
      end

      S_CREDIT: begin
        if (key_any) begin
          // Any key, even a refused one, restarts the idle timeout and
          // takes precedence over a timeout landing in the same cycle.
          timer_nx = '0;
          if (key_cancel) begin
            state_nx      = S_REFUND;
            change_nx     = balance;
            change_vld_nx = 1'b1;
            balance_nx    = '0;
          end else if (key_select) begin
            if (balance >= 7'(PRICE)) begin
              balance_nx  = balance - 7'(PRICE);
              dispense_nx = 1'b1;
              dcnt_nx     = '0;
              state_nx    = S_VEND;
            end else begin
              reject_nx = 1'b1;
            end
          end else if (key_coin) begin
            if (coin_sum <= 8'(MAX_BAL)) begin
              balance_nx = coin_sum[6:0];
            end else begin
              reject_nx = 1'b1;
            end
          end
        end else if (timer == TIMEOUT_CYC - 1) begin
          timer_nx      = '0;
          state_nx      = S_REFUND;
          change_nx     = balance;
          change_vld_nx = 1'b1;
          balance_nx    = '0;
        end else begin
          timer_nx = timer + 32'd1;
        end
      end

      S_VEND: begin
        if (dcnt == DISP_CYC - 1) begin
          dispense_nx = 1'b0;
          dcnt_nx     = '0;
          if (balance != '0) begin
            state_nx      = S_REFUND;
            change_nx     = balance;
            change_vld_nx = 1'b1;
            balance_nx    = '0;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          dcnt_nx = dcnt + 32'd1;
        end
      end

      S_REFUND: begin
        // Refund outputs were registered on entry; this cycle only holds busy.
        state_nx = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase

    busy_nx = (state_nx == S_VEND) || (state_nx == S_REFUND);
  end

  assign bus.balance    = balance;
  assign bus.dispense   = dispense;
  assign bus.change     = change;
  assign bus.change_vld = change_vld;
  assign bus.reject     = reject;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_vend_ctrl.sv
// Testbench for vend_ctrl: directed scenarios plus random key traffic,
// checked against a transaction-level reference model via an event scoreboard
// and per-cycle status comparison.
module tb_vend_ctrl;

  localparam int DISP = 4;
  localparam int TMO  = 100;

  logic sclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 sclk = ~sclk;

  vend_ctrl_if vif ();

  vend_ctrl #(
    .PRICE(15), .COIN_A(5), .COIN_B(10), .MAX_BAL(95),
    .DISP_CYC(DISP), .TIMEOUT_CYC(TMO)
  ) dut (
    .sclk (sclk),
    .rst_n(rst_n),
    .bus  (vif)
  );

  typedef struct {
    int e;     // edge number at which the event must appear
    int kind;  // 1 reject, 2 change, 3 vend start
    int val;
  } ev_t;

  ev_t ev_q[$];
  int  edge_n = 0;
  int  checks = 0;
  int  errors = 0;

  // Reference model: transaction view with absolute deadlines.
  int m_mode;      // 0 idle, 1 holding credit, 2 vending, 3 refunding
  int m_bal, m_change, m_vend_end, m_deadline;
  bit m_disp, m_busy;

  task automatic push_ev(input int e, input int kind, input int val);
    ev_t ev;
    ev.e = e; ev.kind = kind; ev.val = val;
    ev_q.push_back(ev);
  endtask

  task automatic model_reset();
    m_mode = 0; m_bal = 0; m_change = 0; m_vend_end = 0; m_deadline = 0;
    m_disp = 0; m_busy = 0;
    ev_q.delete();
  endtask

  task automatic model_refund(input int e);
    push_ev(e, 2, m_bal);
    m_change = m_bal;
    m_bal = 0;
    m_mode = 3;
    m_busy = 1;
  endtask

  // Predict the effect of key k sampled at edge e.
  task automatic model_step(input int e, input logic [3:0] k);
    int coin;
    coin = k[1] ? 10 : (k[0] ? 5 : 0);
    case (m_mode)
      3: begin m_mode = 0; m_busy = 0; end
      2: if (e == m_vend_end) begin
           m_disp = 0;
           if (m_bal > 0) model_refund(e);
           else begin m_mode = 0; m_busy = 0; end
         end
      0: if (!k[3]) begin
           if (k[2]) push_ev(e, 1, 0);
           else if (coin > 0) begin
             m_bal = coin; m_mode = 1; m_deadline = e + TMO;
           end
         end
      1: if (k != 4'b0) begin
           m_deadline = e + TMO;
           if (k[3]) model_refund(e);
           else if (k[2]) begin
             if (m_bal >= 15) begin
               m_bal -= 15; m_mode = 2; m_disp = 1; m_busy = 1;
               m_vend_end = e + DISP;
               push_ev(e, 3, m_bal);
             end else push_ev(e, 1, 0);
           end else if (m_bal + coin <= 95) m_bal += coin;
           else push_ev(e, 1, 0);
         end else if (e == m_deadline) model_refund(e);
      default: ;
    endcase
  endtask

  // Monitor: event scoreboard and per-cycle status comparison.
  bit prev_disp = 0;

  task automatic check_event(input bit got, input int kind, input int actual);
    ev_t ev;
    if (got) begin
      checks++;
      if (ev_q.size() > 0 && ev_q[0].e == edge_n && ev_q[0].kind == kind) begin
        ev = ev_q.pop_front();
        if (kind != 1 && actual != ev.val) begin
          errors++;
          $display("FAIL event_val kind=%0d edge=%0d: got %0d expected %0d", kind, edge_n, actual, ev.val);
        end
      end else begin
        errors++;
        $display("FAIL unexpected_event kind=%0d edge=%0d: got event, expected none", kind, edge_n);
      end
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s edge=%0d: got %0d expected %0d", name, edge_n, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge sclk);
      edge_n++;
      #1;
      if (!rst_n) begin
        prev_disp = 0;
        continue;
      end
      check_event(vif.reject, 1, 0);
      check_event(vif.change_vld, 2, int'(vif.change));
      check_event(vif.dispense && !prev_disp, 3, int'(vif.balance));
      while (ev_q.size() > 0 && ev_q[0].e <= edge_n) begin
        checks++;
        errors++;
        $display("FAIL missing_event kind=%0d edge=%0d: got none expected val %0d", ev_q[0].kind, ev_q[0].e, ev_q[0].val);
        void'(ev_q.pop_front());
      end
      check_val("balance", int'(vif.balance), m_bal);
      check_val("dispense", int'(vif.dispense), int'(m_disp));
      check_val("busy", int'(vif.busy), int'(m_busy));
      check_val("change", int'(vif.change), m_change);
      prev_disp = vif.dispense;
    end
  end

  // Driver
  task automatic cycle(input logic [3:0] k);
    @(negedge sclk);
    vif.flag_key = k;
    model_step(edge_n + 1, k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(4'b0);
  endtask

  task automatic check_reset_outputs(input string name);
    check_val({name, "_balance"}, int'(vif.balance), 0);
    check_val({name, "_change"}, int'(vif.change), 0);
    check_val({name, "_strobes"},
              int'({vif.dispense, vif.change_vld, vif.reject, vif.busy}), 0);
  endtask

  task automatic do_reset(input string name);
    @(negedge sclk);
    rst_n = 1'b0;
    vif.flag_key = 4'b0;
    #1;
    check_reset_outputs(name);
    model_reset();
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    logic [3:0] k;
    vif.flag_key = 4'b0;
    model_reset();
    #1;
    check_reset_outputs("reset_init");
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;

    // IDLE: select refused, cancel ignored
    cycle(4'b0100); cycle(4'b1000); idle(2);
    // Exact price
    cycle(4'b0001); cycle(4'b0010); idle(2); cycle(4'b0100); idle(6);
    // Change return
    cycle(4'b0010); cycle(4'b0010); cycle(4'b0100); idle(8);
    // Insufficient funds, then cancel
    cycle(4'b0001); cycle(4'b0100); idle(1); cycle(4'b1000); idle(2);
    // Credit limit
    repeat (9) cycle(4'b0010);
    cycle(4'b0010); cycle(4'b0001); cycle(4'b0001); cycle(4'b1000); idle(2);
    // Timeout, and timeout restarted by a coin
    cycle(4'b0001); idle(110);
    cycle(4'b0001); idle(59); cycle(4'b0001); idle(110);
    // Priority
    cycle(4'b0001); cycle(4'b0010); cycle(4'b1011); idle(3);
    cycle(4'b0001); cycle(4'b0010); cycle(4'b0110);
    cycle(4'b0001); cycle(4'b0010); cycle(4'b0100); idle(5);
    // Reset in the middle of a vend
    cycle(4'b0010); cycle(4'b0010); cycle(4'b0100); idle(1);
    do_reset("reset_mid_vend");
    idle(2);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 19);
      if (r <= 4)       k = 4'b0001;
      else if (r <= 8)  k = 4'b0010;
      else if (r <= 10) k = 4'b0100;
      else if (r == 11) k = 4'b1000;
      else if (r == 12) k = 4'($urandom_range(1, 15));
      else              k = 4'b0000;
      cycle(k);
      if ($urandom_range(0, 99) == 0) idle(105);
    end
    idle(10);

    checks++;
    if (ev_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events: got %0d pending expected 0", ev_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Vending transaction controller. It consumes the four one-cycle debounced key pulses from the key conditioning block: coin 5, coin 10, select, cancel.
- Tracks the inserted credit, issues a timed dispense strobe and returns change. Times out abandoned transactions.
- Sits between the key debounce stage and the display/actuator drivers in the vending machine top level.

Parameters:
- PRICE, 15: item price in jiao.
- COIN_A, 5: value of flag_key[0] coin in jiao.
- COIN_B, 10: value of flag_key[1] coin in jiao.
- MAX_BAL, 95: maximum credit accepted. Must be ≤127.
- DISP_CYC, 50_000_000: dispense strobe length in sclk cycles (1 s at 50 MHz). Must be ≥1.
- TIMEOUT_CYC, 500_000_000: idle-credit timeout in sclk cycles (10 s). Must be ≥1. Timer is 32 bits.

Ports:
- sclk  in  1  system clock, 50 MHz
- rst_n  in  1  reset, asynchronous, active-low
- flag_key  in  4  one-cycle key pulses. [0] coin A, [1] coin B, [2] select, [3] cancel.
- balance  out  7  current credit in jiao
- dispense  out  1  high for exactly DISP_CYC cycles per vend
- change  out  7  refunded amount; holds its value until the next refund
- change_vld  out  1  one-cycle strobe, change valid
- reject  out  1  one-cycle strobe, key event refused
- busy  out  1  high in VEND and REFUND

Behaviour:
- Reset: reset is asynchronous on rst_n, active-low; the block is clocked on sclk. While reset is asserted:
  - state = IDLE;
  - balance, change, the dispense counter and the timeout timer = 0;
  - dispense, change_vld, reject, busy = 0.
- All outputs are registered. A pulse sampled at edge k takes effect in the outputs after edge k, i.e. one cycle latency.
- Key priority when several flag_key bits are set in one cycle: cancel > select > coin B > coin A. Only the highest-priority bit is acted on; the others are discarded with no reject.
- States: IDLE (balance = 0), CREDIT (balance > 0), VEND, REFUND.
- IDLE:
  - coin → balance = coin value, go to CREDIT;
  - select → reject pulse, stay in IDLE;
  - cancel → no effect.
- CREDIT, coin:
  - if balance + coin ≤ MAX_BAL → add it;
  - otherwise → reject pulse, balance unchanged.
- CREDIT, select:
  - if balance ≥ PRICE → balance -= PRICE, dispense = 1, go to VEND;
  - otherwise → reject pulse.
- CREDIT, cancel → go to REFUND.
- CREDIT timeout:
  - The timer counts every cycle while in CREDIT.
  - It clears to 0 on any nonzero flag_key, including rejected events.
  - When the timer reaches TIMEOUT_CYC-1 → go to REFUND.
  - If a key pulse arrives in that same cycle, the key wins and the timer clears.
- VEND:
  - dispense stays high for DISP_CYC cycles in total.
  - All flag_key pulses are ignored silently: no reject, no timer effect.
  - At the end, dispense = 0. Then go to REFUND if balance > 0, else to IDLE.
- REFUND, exactly one cycle: change = balance, change_vld = 1, balance = 0, then go to IDLE. flag_key is ignored in this cycle.
- busy = 1 exactly while in VEND or REFUND.
- Reset asserted mid-VEND or mid-REFUND aborts immediately to reset values. No change is issued; credit is lost by design.
- Arithmetic: 7-bit unsigned. The overflow test uses an 8-bit sum, so no wrap-around can occur.

Test Plan:
- Exact price: with DISP_CYC=4, pulse coin A then coin B.
  - balance goes 5 then 15.
  - select → dispense is high for exactly 4 cycles, balance = 0, busy high for 4 cycles, no change_vld, state returns to IDLE.
- Change return: pulse coin B twice (balance 20), then select.
  - balance reads 5 during the dispense window.
  - After dispense falls: change_vld for 1 cycle with change = 5, then balance = 0.
- Insufficient funds and cancel: pulse coin A, then select.
  - reject for 1 cycle, balance stays 5.
  - cancel → change_vld with change = 5, balance = 0.
- Overflow: pulse coin B 9 times (balance 90).
  - Next coin B → reject, balance stays 90.
  - Coin A → balance 95; another coin A → reject.
- Timeout: with TIMEOUT_CYC=100, pulse coin A and wait.
  - change_vld with change = 5 occurs exactly 100 cycles after balance becomes nonzero.
  - Repeat, pulsing coin A at cycle 60: the timeout restarts and fires 100 cycles after that pulse, with change = 10.
- Priority and lockout:
  - flag_key=4'b1011 with balance 15 → treated as cancel: change = 15, no coin added.
  - flag_key=4'b0110 with balance 15 → vend.
  - Coin pulses during VEND → ignored: no reject, balance unchanged.
  - Reset asserted mid-VEND → all outputs 0 immediately.
